// File: rtl/load_store_fns_pkg.sv
// rtl/load_store_fns_pkg.sv - load/store funct3 encodings shared by the core
package LOAD_STORE_FNS;

    typedef enum logic [2:0] {
        BYTE   = 3'b000,
        HALF   = 3'b001,
        WORD   = 3'b010,
        BYTE_U = 3'b100,
        HALF_U = 3'b101
    } funct3_t;

endpackage

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - lsu_ctrl state/error types and command legality check
package lsu_pkg;
    import LOAD_STORE_FNS::*;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;

    typedef enum logic [1:0] {
        ERR_OK         = 2'd0,
        ERR_MISALIGNED = 2'd1,
        ERR_ILLEGAL    = 2'd2,
        ERR_TIMEOUT    = 2'd3
    } lsu_err_t;

    // Illegal encodings are checked after alignment so they override it.
    function automatic lsu_err_t lsu_check(input logic we, input funct3_t funct3,
                                           input logic [1:0] offset);
        lsu_err_t err;
        case (funct3)
            BYTE, BYTE_U: err = ERR_OK;
            HALF, HALF_U: err = offset[0] ? ERR_MISALIGNED : ERR_OK;
            WORD:         err = (offset != 2'b00) ? ERR_MISALIGNED : ERR_OK;
            default:      err = ERR_ILLEGAL;
        endcase
        if (we && (funct3 == BYTE_U || funct3 == HALF_U)) begin
            err = ERR_ILLEGAL;
        end
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores and load extraction/extension
module lsu_align
    import LOAD_STORE_FNS::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_mem_wdata,
    output logic [3:0]  st_mem_be,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        st_mem_wdata = st_wdata;
        st_mem_be    = 4'b0000;
        case (funct3_t'(st_funct3))
            BYTE, BYTE_U: begin
                st_mem_wdata = {4{st_wdata[7:0]}};
                st_mem_be    = 4'b0001 << st_offset;
            end
            HALF, HALF_U: begin
                st_mem_wdata = {2{st_wdata[15:0]}};
                st_mem_be    = 4'b0011 << st_offset;
            end
            WORD: begin
                st_mem_wdata = st_wdata;
                st_mem_be    = 4'b1111;
            end
            default: begin
                st_mem_wdata = st_wdata;
                st_mem_be    = 4'b0000;
            end
        endcase
    end

    always_comb begin
        shifted = ld_rdata >> {ld_offset, 3'b000};
        case (funct3_t'(ld_funct3))
            BYTE:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            HALF:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            WORD:    ld_data = shifted;
            BYTE_U:  ld_data = {24'd0, shifted[7:0]};
            HALF_U:  ld_data = {16'd0, shifted[15:0]};
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer between execute stage and data-memory port
module lsu_ctrl
    import LOAD_STORE_FNS::*;
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam bit             WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] WD_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_t      state;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [1:0]      offset_q;
    logic [TO_W-1:0] wd;
    lsu_err_t        chk_err;
    logic [31:0]     st_wdata;
    logic [3:0]      st_be;
    logic [31:0]     ld_data;

    assign req_ready = (state == IDLE) && !rst;
    assign chk_err   = lsu_check(req_we, funct3_t'(req_funct3), req_addr[1:0]);

    lsu_align u_align (
        .st_funct3    (req_funct3),
        .st_offset    (req_addr[1:0]),
        .st_wdata     (req_wdata),
        .st_mem_wdata (st_wdata),
        .st_mem_be    (st_be),
        .ld_funct3    (funct3_q),
        .ld_offset    (offset_q),
        .ld_rdata     (mem_rdata),
        .ld_data      (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            funct3_q      <= 3'd0;
            offset_q      <= 2'd0;
            wd            <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'd0;
            resp_err      <= ERR_OK;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'd0;
            mem_wdata     <= 32'd0;
            mem_be        <= 4'd0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        offset_q <= req_addr[1:0];
                        if (chk_err != ERR_OK) begin
                            resp_valid <= 1'b1;
                            resp_err   <= chk_err;
                            resp_rdata <= 32'd0;
                            state      <= RESP;
                        end else begin
                            mem_req_valid <= 1'b1;
                            mem_we        <= req_we;
                            mem_addr      <= {req_addr[31:2], 2'b00};
                            mem_wdata     <= st_wdata;
                            mem_be        <= req_we ? st_be : 4'b0000;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        wd            <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // A completion arriving on the final watchdog cycle still counts.
                    if (mem_rvalid) begin
                        resp_valid <= 1'b1;
                        resp_err   <= ERR_OK;
                        resp_rdata <= we_q ? 32'd0 : ld_data;
                        state      <= RESP;
                    end else if (WD_EN && wd == WD_LAST) begin
                        resp_valid <= 1'b1;
                        resp_err   <= ERR_TIMEOUT;
                        resp_rdata <= 32'd0;
                        state      <= RESP;
                    end else begin
                        wd <= wd + TO_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the core's execute stage and a single data-memory port.
- Accepts one LOAD/STORE command at a time and checks alignment and funct3 legality.
- Builds word-aligned memory requests with byte enables, waits for memory completion, and returns sign/zero-extended load data or an error code.
- Sequential core: 4-state FSM plus a completion watchdog counter.

Parameters:
- TIMEOUT_CYCLES, 64: max WAIT cycles before a timeout error; 0 disables the watchdog.
- TO_W, 8: width of the watchdog counter; must satisfy 2**TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core presents a command
- req_ready  out  1  block can accept a command
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  LOAD_STORE_FNS funct3 (BYTE/HALF/WORD/BYTE_U/HALF_U)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  2  lsu_err_t: 0 OK, 1 MISALIGNED, 2 ILLEGAL, 3 TIMEOUT
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  write request
- mem_addr  out  32  {req_addr[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables (0 for loads)
- mem_rvalid  in  1  completion pulse for both reads and writes
- mem_rdata  in  32  read word, valid with mem_rvalid

Behaviour:
- Reset: state = IDLE; all registered outputs 0 (resp_valid, resp_rdata, resp_err, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be); watchdog = 0.
- req_ready = (state == IDLE) && !rst, combinational.
- Reset mid-operation: abandons any in-flight access; no response is issued.
- IDLE
  - On req_valid && req_ready: latch we, funct3, addr, wdata.
  - ILLEGAL when funct3 is in {011, 110, 111}, or when a store uses 100/101. ILLEGAL -> RESP.
  - Else MISALIGNED when HALF/HALF_U has addr[0] = 1, or WORD has addr[1:0] != 0. MISALIGNED -> RESP.
  - ILLEGAL takes priority over MISALIGNED.
  - Otherwise -> REQ.
- REQ
  - mem_req_valid = 1. mem_addr, mem_we, mem_wdata and mem_be are held stable until mem_req_ready.
  - On handshake -> WAIT; watchdog cleared.
  - mem_rvalid is ignored in IDLE, REQ and RESP.
- WAIT
  - mem_req_valid = 0.
  - mem_rvalid -> RESP with err OK. Load data: shift mem_rdata right by 8*addr[1:0], then sign- or zero-extend per funct3. Store: rdata = 0.
  - No rvalid: watchdog increments. When watchdog == TIMEOUT_CYCLES-1 and TIMEOUT_CYCLES != 0 -> RESP with TIMEOUT.
  - rvalid in that same cycle wins; the response is OK.
- RESP
  - resp_valid = 1 for exactly one cycle; no backpressure -> IDLE.
- Store lanes
  - BYTE: mem_wdata = {4{wdata[7:0]}}, mem_be = 4'b0001 << addr[1:0].
  - HALF: mem_wdata = {2{wdata[15:0]}}, mem_be = 4'b0011 << addr[1:0].
  - WORD: mem_wdata = wdata, mem_be = 4'b1111.
- Latency from accept cycle T:
  - Errors: resp_valid at T+1.
  - Memory accesses: earliest resp_valid at T+3 (ready at T+1, rvalid at T+2).
- Throughput: next accept no earlier than the cycle after RESP.
- A late mem_rvalid after a timeout is ignored while not in WAIT. The memory must not deliver a stale completion into a later WAIT.

Decomposition:
- Package lsu_pkg:
  - lsu_state_t {IDLE, REQ, WAIT, RESP}
  - lsu_err_t
  - Imports LOAD_STORE_FNS::funct3_t; no duplicated funct3 encodings.
- Sub-module lsu_align, purely combinational:
  - Store side: (funct3, addr[1:0], wdata) -> (mem_wdata, mem_be).
  - Load side: (funct3, addr[1:0], mem_rdata) -> extended rdata.
  - Unit-testable separately.

Test Plan:
- Load BYTE, addr 0x1003, mem_rdata 0x80AABBCC, ready immediate, rvalid 1 cycle later -> resp_rdata 0xFFFFFF80, err 0, resp_valid at T+3.
- Load HALF_U, addr 0x2002, mem_rdata 0xBEEF1234 -> resp_rdata 0x0000BEEF; HALF at the same address -> 0xFFFFBEEF.
- Store HALF, addr 0x3002, wdata 0x0000A5A5, mem_req_ready held low 3 cycles -> mem_req_valid held with stable mem_addr 0x3000, mem_be 1100, mem_wdata 0xA5A5A5A5; resp after rvalid.
- Load WORD at addr 0x4001 -> resp err 1 at T+1, no mem_req_valid. Store funct3 100 -> err 2. Load funct3 111 at addr 0x4001 -> err 2 (ILLEGAL priority).
- TIMEOUT_CYCLES = 4, never assert rvalid -> err 3 exactly 4 WAIT cycles after handshake. Repeat with rvalid in the 4th WAIT cycle -> err 0.
- Assert rst during WAIT -> next cycle IDLE, req_ready 1, no resp_valid; a subsequent word load completes normally.
